// File: rtl/uart_tx_scheduler_if.sv
// Bundle of request-side and UART-side signals for the UART TX scheduler.
// The master side is the client/UART environment; the slave side is the scheduler.
interface uart_tx_scheduler_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_par_en;
   logic [NUM_REQ-1:0]            req_ready;
   logic [DATA_WIDTH-1:0]         tx_data;
   logic                          tx_par_en;
   logic                          tx_data_valid;
   logic                          tx_busy;
   logic [ID_W-1:0]               grant_id;
   logic                          sched_busy;
   logic                          timeout_err;

   modport master (
      output req_valid, req_data, req_par_en, tx_busy,
      input  req_ready, tx_data, tx_par_en, tx_data_valid, grant_id, sched_busy, timeout_err
   );

   modport slave (
      input  req_valid, req_data, req_par_en, tx_busy,
      output req_ready, tx_data, tx_par_en, tx_data_valid, grant_id, sched_busy, timeout_err
   );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
// One byte is captured per grant, launched with a single-cycle valid pulse, and the
// byte/parity config is held until the UART reports the end of the frame.
module uart_tx_scheduler #(
   parameter int DATA_WIDTH   = 8,
   parameter int NUM_REQ      = 4,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst,
   uart_tx_scheduler_if.slave bus
);
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LAUNCH    = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_t;

   state_t                state_r, state_nx_s;
   logic [ID_W-1:0]       ptr_r, ptr_nx_s;
   logic [CNT_W-1:0]      cnt_r, cnt_nx_s;
   logic [ID_W-1:0]       pick_idx_s;
   logic                  pick_found_s;
   logic                  grant_s;
   logic                  cnt_expired_s;

   logic [NUM_REQ-1:0]    req_ready_r, req_ready_nx_s;
   logic [DATA_WIDTH-1:0] tx_data_r, tx_data_nx_s;
   logic                  tx_par_en_r, tx_par_en_nx_s;
   logic                  tx_data_valid_r, tx_data_valid_nx_s;
   logic [ID_W-1:0]       grant_id_r, grant_id_nx_s;
   logic                  sched_busy_r, sched_busy_nx_s;
   logic                  timeout_err_r, timeout_err_nx_s;

   // Round-robin search: first valid requester starting just after the last grant.
   always_comb begin
      pick_found_s = 1'b0;
      pick_idx_s   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!pick_found_s && bus.req_valid[ID_W'((int'(ptr_r) + k) % NUM_REQ)]) begin
            pick_found_s = 1'b1;
            pick_idx_s   = ID_W'((int'(ptr_r) + k) % NUM_REQ);
         end else begin
            pick_found_s = pick_found_s;
         end
      end
   end

   // A grant needs a pending byte and an idle transmitter.
   assign grant_s       = pick_found_s & ~bus.tx_busy;
   assign cnt_expired_s = (cnt_r == CNT_W'(BUSY_TIMEOUT - 1));

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic for the IDLE -> LAUNCH -> WAIT_BUSY -> WAIT_DONE frame cycle.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (grant_s) state_nx_s = ST_LAUNCH;
            else         state_nx_s = ST_IDLE;
         end
         ST_LAUNCH: begin
            state_nx_s = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (bus.tx_busy)        state_nx_s = ST_WAIT_DONE;
            else if (cnt_expired_s) state_nx_s = ST_IDLE;
            else                    state_nx_s = ST_WAIT_BUSY;
         end
         ST_WAIT_DONE: begin
            if (bus.tx_busy) state_nx_s = ST_WAIT_DONE;
            else             state_nx_s = ST_IDLE;
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Next values of the registered outputs, pointer and busy-wait counter.
   always_comb begin
      req_ready_nx_s     = '0;
      tx_data_valid_nx_s = 1'b0;
      timeout_err_nx_s   = 1'b0;
      tx_data_nx_s       = tx_data_r;
      tx_par_en_nx_s     = tx_par_en_r;
      grant_id_nx_s      = grant_id_r;
      ptr_nx_s           = ptr_r;
      cnt_nx_s           = cnt_r;
      sched_busy_nx_s    = (state_nx_s != ST_IDLE);
      case (state_r)
         ST_IDLE: begin
            if (grant_s) begin
               req_ready_nx_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
               tx_data_nx_s   = bus.req_data[int'(pick_idx_s)*DATA_WIDTH +: DATA_WIDTH];
               tx_par_en_nx_s = bus.req_par_en[pick_idx_s];
               grant_id_nx_s  = pick_idx_s;
               ptr_nx_s       = pick_idx_s;
            end else begin
               req_ready_nx_s = '0;
            end
         end
         ST_LAUNCH: begin
            tx_data_valid_nx_s = 1'b1;
            cnt_nx_s           = '0;
         end
         ST_WAIT_BUSY: begin
            if (bus.tx_busy) begin
               cnt_nx_s = cnt_r;
            end else if (cnt_expired_s) begin
               timeout_err_nx_s = 1'b1;
            end else if (cnt_r != {CNT_W{1'b1}}) begin
               cnt_nx_s = cnt_r + CNT_W'(1);
            end else begin
               cnt_nx_s = cnt_r;
            end
         end
         ST_WAIT_DONE: begin
            cnt_nx_s = cnt_r;
         end
         default: begin
            cnt_nx_s = '0;
         end
      endcase
   end

   // Output, pointer and counter registers; the pointer resets so requester 0 wins first.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_ready_r     <= '0;
         tx_data_r       <= '0;
         tx_par_en_r     <= 1'b0;
         tx_data_valid_r <= 1'b0;
         grant_id_r      <= '0;
         sched_busy_r    <= 1'b0;
         timeout_err_r   <= 1'b0;
         ptr_r           <= ID_W'(NUM_REQ - 1);
         cnt_r           <= '0;
      end else begin
         req_ready_r     <= req_ready_nx_s;
         tx_data_r       <= tx_data_nx_s;
         tx_par_en_r     <= tx_par_en_nx_s;
         tx_data_valid_r <= tx_data_valid_nx_s;
         grant_id_r      <= grant_id_nx_s;
         sched_busy_r    <= sched_busy_nx_s;
         timeout_err_r   <= timeout_err_nx_s;
         ptr_r           <= ptr_nx_s;
         cnt_r           <= cnt_nx_s;
      end
   end

   assign bus.req_ready     = req_ready_r;
   assign bus.tx_data       = tx_data_r;
   assign bus.tx_par_en     = tx_par_en_r;
   assign bus.tx_data_valid = tx_data_valid_r;
   assign bus.grant_id      = grant_id_r;
   assign bus.sched_busy    = sched_busy_r;
   assign bus.timeout_err   = timeout_err_r;
endmodule
